prbs_gen_param: RTL
===================

# prbs_gen_param

Parametrised pattern-preamble plus PRBS generator for the link test path. It replays a programmable preamble word a configurable number of times, then switches to a runtime-selectable PRBS7/15/23/31 LFSR stream. Output is DATA_W bits per beat over a valid/ready handshake. It feeds the serializer and the pattern-detector test harness, replacing the fixed 8-bit PRBS15 source.

## Interface
- DATA_W, 8: output word width; must be 1..32 and divide PATTERN_W.
- PATTERN_W, 32: preamble pattern width.
- REPEAT_W, 8: width of the repeat count.
- Clock and reset: clock clk; reset rst_n, asynchronous, active-low.
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; begins a sequence when IDLE; ignored otherwise.
- stop  in  1  pulse; aborts to IDLE from any state; has priority over start.
- poly_sel  in  2  0=PRBS7, 1=PRBS15, 2=PRBS23, 3=PRBS31; sampled on start.
- seed  in  31  LFSR seed; low L bits are used; sampled on start.
- pattern_in  in  PATTERN_W  preamble; sampled on start.
- n_repeats  in  REPEAT_W  preamble repeat count; sampled on start.
- out_ready  in  1  downstream accept.
- out_valid  out  1  prbs_out is valid.
- prbs_out  out  DATA_W  output word.
- busy  out  1  high in PREAMBLE or PRBS.
- in_prbs  out  1  the current word is from the LFSR phase.

## Operation
- FSM states:
  - IDLE to PREAMBLE on start if n_repeats≠0.
  - IDLE to PRBS on start if n_repeats=0.
  - PREAMBLE to PRBS after the last preamble word is accepted.
  - PRBS runs until stop.
  - Any state to IDLE on stop.
- Preamble: K=PATTERN_W/DATA_W words per repeat, least-significant slice first (word k = pattern_in[k*DATA_W +: DATA_W]). n_repeats×K words total. The word index wraps K-1 to 0 and the repeat counter increments on each wrap.
- LFSR length L and taps (Fibonacci), with s = state[L-1:0], fb = s[L-1]^s[t-1], s <= {s[L-2:0], fb}, emitted bit = fb:
  - PRBS7: L=7, t=6.
  - PRBS15: L=15, t=14.
  - PRBS23: L=23, t=18.
  - PRBS31: L=31, t=28.
- An all-zero seed (low L bits) is replaced with all-ones.
- Each PRBS word holds DATA_W consecutive bits; the first generated bit is in prbs_out[DATA_W-1]. The LFSR advances DATA_W steps per accepted word, unrolled combinationally so the rate is one word per cycle.
- Reset values:
  - State IDLE.
  - out_valid=0, prbs_out=0, busy=0, in_prbs=0.
  - Counters 0; LFSR all-ones.

## Timing
- start sampled in cycle N gives out_valid=1 with the first word in cycle N+1.
- A word transfers when out_valid && out_ready. Next word appears the following cycle, so full throughput is one word per clk.
- While out_valid && !out_ready, prbs_out, in_prbs and the LFSR are held stable.
- PREAMBLE to PRBS has no bubble: the first PRBS word is presented the cycle after the last preamble word is accepted.
- stop in cycle N gives out_valid=0 and busy=0 in cycle N+1. A word pending in cycle N is dropped.
- start and stop in the same cycle: stop wins and the block stays IDLE.
- start while busy is ignored. Input changes after start do not affect the running sequence.
- rst_n asserted mid-sequence clears everything immediately (asynchronous). Operation resumes only after a new start.

## Configuration
- PRBS_ERR_INJ_EN defined:
  - Adds input inj_err (1 bit). A pulse arms a one-shot that XORs bit 0 of the next PRBS-phase word with 1.
  - The LFSR state is not corrupted.
  - The arm clears when that word is accepted. Pulses during PREAMBLE stay armed until the first PRBS word.
- PRBS_ERR_INJ_EN undefined: no inj_err port and no injection logic; output is the pure sequence.

## Test plan
- DATA_W=8, pattern 32'hA5C3_0F81, n_repeats=2, poly=0, seed=7'h7F, out_ready=1 -> 81,0F,C3,A5,81,0F,C3,A5, then PRBS words 8'h02, 8'h0C; in_prbs rises on the 02 word.
- n_repeats=0, PRBS7 seed 0 -> same as seed 7'h7F: first words 02, 0C. Run 127 words (1016 bits) and check that the bit stream repeats with period 127.
- Randomly toggle out_ready in the PRBS15 phase -> prbs_out stable while stalled. The accepted-word stream matches a reference model of x^15+x^14+1 with no gaps or duplicates.
- stop mid-preamble, then start with poly=3 -> out_valid drops next cycle. The new sequence restarts at preamble word 0, and the PRBS31 stream matches the reference model.
- Assert rst_n low during PRBS, release, then start -> outputs are 0 during reset and the first word after start is pattern slice 0.
- With PRBS_ERR_INJ_EN: pulse inj_err during the preamble -> exactly one word differs from the model (the first PRBS word, bit 0), and later words match.

Source files
------------

// File: rtl/prbs_gen_param.sv
// prbs_gen_param: replays a preamble word n_repeats times, then streams PRBS7/15/23/31 words over valid/ready
// Ports: clk, rst_n (async active-low); start/stop pulses (stop wins); poly_sel, seed, pattern_in, n_repeats sampled on start;
//        out_ready in; out_valid, prbs_out[DATA_W], busy, in_prbs out.
// Build option: define PRBS_ERR_INJ_EN to add inj_err, a one-shot bit-0 flip of the next PRBS word.
module prbs_gen_param #(
  parameter int DATA_W    = 8,
  parameter int PATTERN_W = 32,
  parameter int REPEAT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic [1:0]           poly_sel,
  input  logic [30:0]          seed,
  input  logic [PATTERN_W-1:0] pattern_in,
  input  logic [REPEAT_W-1:0]  n_repeats,
  input  logic                 out_ready,
`ifdef PRBS_ERR_INJ_EN
  input  logic                 inj_err,
`endif
  output logic                 out_valid,
  output logic [DATA_W-1:0]    prbs_out,
  output logic                 busy,
  output logic                 in_prbs
);
  localparam int K  = PATTERN_W / DATA_W;
  localparam int IW = K > 1 ? $clog2(K) : 1;
  typedef enum logic [1:0] {IDLE, PREAMBLE, PRBS} state_t;
  state_t state, state_nx;
  logic [1:0] poly;
  logic [30:0] lfsr, lfsr_nx, seed_m;
  logic [PATTERN_W-1:0] pattern;
  logic [REPEAT_W-1:0] n_rep, rep;
  logic [IW-1:0] idx;
  logic [DATA_W-1:0] prbs_word, inj_mask;
  logic accept, wrap, last_word, go;
  function automatic logic [30:0] len_mask(input logic [1:0] p);
    return p == 2'd0 ? 31'h7F : p == 2'd1 ? 31'h7FFF : p == 2'd2 ? 31'h7F_FFFF : 31'h7FFF_FFFF;
  endfunction
  function automatic logic [30:0] step(input logic [30:0] s, input logic [1:0] p);
    logic fb;
    fb = p == 2'd0 ? s[6] ^ s[5] : p == 2'd1 ? s[14] ^ s[13] : p == 2'd2 ? s[22] ^ s[17] : s[30] ^ s[27];
    return {s[29:0], fb} & len_mask(p);
  endfunction
  // DATA_W LFSR steps unrolled; the first generated bit lands in the MSB
  always_comb begin
    prbs_word = '0;
    lfsr_nx = lfsr;
    for (int i = 0; i < DATA_W; i++) begin
      lfsr_nx = step(lfsr_nx, poly);
      prbs_word[DATA_W-1-i] = lfsr_nx[0];
    end
  end
  assign accept    = out_valid & out_ready;
  assign wrap      = idx == IW'(K - 1);
  assign last_word = wrap && (rep + 1'b1) == n_rep;
  assign go        = state == IDLE && start && !stop;
  assign seed_m    = |(seed & len_mask(poly_sel)) ? seed & len_mask(poly_sel) : len_mask(poly_sel);
  always_comb begin
    state_nx = stop ? IDLE
             : go ? (|n_repeats ? PREAMBLE : PRBS)
             : (state == PREAMBLE && accept && last_word) ? PRBS
             : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      poly    <= '0;
      lfsr    <= '1;
      pattern <= '0;
      n_rep   <= '0;
      rep     <= '0;
      idx     <= '0;
    end else if (go) begin
      poly    <= poly_sel;
      lfsr    <= seed_m;
      pattern <= pattern_in;
      n_rep   <= n_repeats;
      rep     <= '0;
      idx     <= '0;
    end else if (accept && state == PREAMBLE) begin
      idx <= wrap ? '0 : idx + 1'b1;
      rep <= wrap ? rep + 1'b1 : rep;
    end else if (accept && state == PRBS) begin
      lfsr <= lfsr_nx;
    end
`ifdef PRBS_ERR_INJ_EN
  logic armed;
  // armed survives the preamble and clears only once the corrupted PRBS word is taken
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) armed <= 1'b0;
    else armed <= (armed & ~(accept && state == PRBS)) | inj_err;
  assign inj_mask = DATA_W'(armed);
`else
  assign inj_mask = '0;
`endif
  assign out_valid = state != IDLE;
  assign busy      = state != IDLE;
  assign in_prbs   = state == PRBS;
  assign prbs_out  = state == PRBS ? prbs_word ^ inj_mask
                   : state == PREAMBLE ? pattern[int'(idx)*DATA_W +: DATA_W]
                   : '0;
endmodule
